// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular add/subtract datapath.
package mod_arith_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Internal arithmetic width: one extra bit holds the carry of a sum
   // or the sign (borrow) of a difference.
   function automatic int ext_width(input int width);
      return width + 1;
   endfunction

   // Per-beat control that travels alongside the data in every stage.
   typedef struct packed {
      logic s;    // OP_ADD / OP_SUB
      logic err;  // an operand was outside [0, M-1]
   } op_tag_t;

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Operand/result handshake bundle for mod_addsub_pipe.
// master = operand source + result consumer, slave = the pipeline.
interface mod_addsub_pipe_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_s;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_z;
   logic             out_err;

   modport master (
      output in_valid, in_s, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_z, out_err
   );

   modport slave (
      input  in_valid, in_s, in_a, in_b, out_ready,
      output in_ready, out_valid, out_z, out_err
   );
endinterface

// File: rtl/mod_result_select.sv
// Final-stage choice between the raw value v and the corrected value w,
// with error beats forced to zero.
module mod_result_select
   import mod_arith_pkg::*;
#(
   parameter  int WIDTH   = 4,
   parameter  int MODULUS = 13,
   localparam int EW      = ext_width(WIDTH)
) (
   input  logic             s,
   input  logic             err,
   input  logic [EW-1:0]    v,
   input  logic [EW-1:0]    w,
   output logic [WIDTH-1:0] z
);

   localparam logic [EW-1:0] M_EXT = EW'(MODULUS);

   logic use_w;

   // Add wraps when the sum reaches M; subtract wraps when it borrowed
   // (sign bit of the extended difference set).
   always_comb begin
      use_w = 1'b0;
      z     = '0;
      if (s == OP_ADD) use_w = (v >= M_EXT);
      else             use_w = v[EW-1];
      if (!err) z = WIDTH'(use_w ? w : v);
   end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Three-stage (a +/- b) mod M pipeline with valid/ready on both sides.
// S1 registers operands and the range check, S2 registers raw and
// corrected candidates, S3 registers the chosen result.
module mod_addsub_pipe
   import mod_arith_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   mod_addsub_pipe_if.slave  bus
);

   localparam int EW = ext_width(WIDTH);

   if (MODULUS < 2 || MODULUS > (2 ** WIDTH) - 1) begin : g_bad_modulus
      $error("mod_addsub_pipe: MODULUS must lie in [2, 2**WIDTH-1]");
   end

   localparam logic [WIDTH-1:0] M_W   = WIDTH'(MODULUS);
   localparam logic [EW-1:0]    M_EXT = EW'(MODULUS);

   typedef struct packed {
      op_tag_t          tag;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } s1_t;

   typedef struct packed {
      op_tag_t       tag;
      logic [EW-1:0] v;
      logic [EW-1:0] w;
   } s2_t;

   typedef struct packed {
      logic [WIDTH-1:0] z;
      logic             err;
   } s3_t;

   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   s3_t  s3_q, s3_d;
   logic ld1, ld2, ld3;
   logic [EW-1:0]    a_ext, b_ext, v_calc, w_calc;
   logic [WIDTH-1:0] z_sel;

   // A stage may load when it is empty or when its contents move on;
   // the chain collapses bubbles and never looks at in_valid.
   always_comb begin
      ld3 = !v3_q || bus.out_ready;
      ld2 = !v2_q || ld3;
      ld1 = !v1_q || ld2;
   end

   assign bus.in_ready  = ld1;
   assign bus.out_valid = v3_q;
   assign bus.out_z     = s3_q.z;
   assign bus.out_err   = s3_q.err;

   // S2 arithmetic: candidates are sized so neither can overflow.
   always_comb begin
      a_ext = {1'b0, s1_q.a};
      b_ext = {1'b0, s1_q.b};
      if (s1_q.tag.s == OP_ADD) begin
         v_calc = a_ext + b_ext;
         w_calc = v_calc - M_EXT;
      end else begin
         v_calc = a_ext - b_ext;
         w_calc = v_calc + M_EXT;
      end
   end

   mod_result_select #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_select (
      .s   (s2_q.tag.s),
      .err (s2_q.tag.err),
      .v   (s2_q.v),
      .w   (s2_q.w),
      .z   (z_sel)
   );

   // Next-state of every stage; payload only moves with a valid beat.
   always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      v3_d = v3_q;
      s1_d = s1_q;
      s2_d = s2_q;
      s3_d = s3_q;
      if (ld1) begin
         v1_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_d.tag.s   = bus.in_s;
            s1_d.tag.err = (bus.in_a >= M_W) || (bus.in_b >= M_W);
            s1_d.a       = bus.in_a;
            s1_d.b       = bus.in_b;
         end
      end
      if (ld2) begin
         v2_d = v1_q;
         if (v1_q) begin
            s2_d.tag = s1_q.tag;
            s2_d.v   = v_calc;
            s2_d.w   = w_calc;
         end
      end
      if (ld3) begin
         v3_d = v2_q;
         if (v2_q) begin
            s3_d.z   = z_sel;
            s3_d.err = s2_q.tag.err;
         end
      end
   end

   // Stage registers; reset empties the pipe and clears the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

endmodule
